// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Time-multiplexes a DIGITS-wide hex value onto a common-anode 7-segment
//   display. The divided slow clock from the clock divider is synchronised
//   into the clk_in domain and edge-detected, giving one scan tick per rise.
//   Each tick advances to the next digit. A one-cycle all-off blanking phase
//   is placed between digits to suppress ghosting. The displayed value is
//   captured once per full scan, so a frame never mixes old and new digits.
//
// Parameters:
//   DIGITS       number of multiplexed digits (2..8)
//
// Ports:
//   clk_in       system clock; all logic runs on its rising edge
//   rst_n        asynchronous active-low reset
//   slow_clk_in  divided clock, asynchronous to clk_in, treated as data
//   enable       scan enable; low forces the display dark
//   value        hex nibbles, value[3:0] is digit 0 (rightmost)
//   dp_in        decimal points, bit i belongs to digit i, active-high
//   an           anode selects, active-low, registered
//   seg          segments {g,f,e,d,c,b,a}, active-low, registered
//   dp           decimal point, active-low, registered
//   digit_idx    index of the digit currently shown, registered
//
// Optional feature:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, digits above the highest
//   nonzero nibble of the captured value have all segments off. Digit 0 is
//   always decoded, so a value of zero still shows a single "0".
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        slow_clk_in,
    input  logic                        enable,
    input  logic [4*DIGITS-1:0]         value,
    input  logic [DIGITS-1:0]           dp_in,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t state, state_next;

    logic s1, s2, p;
    logic tick;

    logic [4*DIGITS-1:0] snap_val, snap_val_next;
    logic [DIGITS-1:0]   snap_dp, snap_dp_next;

    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [IDX_W-1:0]    idx_next;
    logic [3:0]          nibble;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0]    top_idx;
`endif

    // Active-low segment patterns {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Two-flop synchroniser for the slow clock plus a delayed copy used to
    // detect its rising edge. The slow clock is only ever sampled as data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= slow_clk_in;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign tick = s2 & ~p;

    // State, snapshot and all display outputs are registered together so the
    // pins change only on clock edges and never glitch between digits.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap_val  <= '0;
            snap_dp   <= '0;
            an        <= '1;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            digit_idx <= '0;
        end else begin
            state     <= state_next;
            snap_val  <= snap_val_next;
            snap_dp   <= snap_dp_next;
            an        <= an_next;
            seg       <= seg_next;
            dp        <= dp_next;
            digit_idx <= idx_next;
        end
    end

    // Next-state and next-output logic. The output values computed here are
    // what the pins will show once the transition has happened, so entering
    // SHOW decodes the newly selected digit from the snapshot as it will be
    // after this edge (including a fresh capture when wrapping to digit 0).
    always_comb begin
        state_next    = state;
        snap_val_next = snap_val;
        snap_dp_next  = snap_dp;
        an_next       = an;
        seg_next      = seg;
        dp_next       = dp;
        idx_next      = digit_idx;
        nibble        = 4'h0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        top_idx       = '0;
`endif

        case (state)
            IDLE: begin
                an_next  = '1;
                seg_next = 7'h7F;
                dp_next  = 1'b1;
                if (enable && tick) begin
                    state_next = BLANK;
                    // Parked on the last digit so the first advance wraps to
                    // digit 0 and takes a fresh snapshot.
                    idx_next   = IDX_W'(DIGITS - 1);
                end
            end

            BLANK: begin
                // A tick landing here is ignored; blanking is always one cycle.
                state_next = SHOW;
                idx_next   = (digit_idx == IDX_W'(DIGITS - 1)) ? '0
                                                                : digit_idx + 1'b1;
                if (idx_next == '0) begin
                    snap_val_next = value;
                    snap_dp_next  = dp_in;
                end
                nibble   = snap_val_next[{idx_next, 2'b00} +: 4];
                an_next  = ~(DIGITS'(1) << idx_next);
                seg_next = hex_to_seg(nibble);
                dp_next  = ~snap_dp_next[idx_next];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                for (int i = 1; i < DIGITS; i++) begin
                    if (snap_val_next[i*4 +: 4] != 4'h0) begin
                        top_idx = IDX_W'(i);
                    end
                end
                if (idx_next > top_idx) begin
                    seg_next = 7'h7F;
                end
`endif
            end

            SHOW: begin
                if (tick) begin
                    state_next = BLANK;
                    an_next    = '1;
                    seg_next   = 7'h7F;
                    dp_next    = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                an_next    = '1;
                seg_next   = 7'h7F;
                dp_next    = 1'b1;
            end
        endcase

        // Dropping enable overrides everything: dark on the very next edge.
        // The snapshot is kept; the restart path recaptures it anyway.
        if (!enable) begin
            state_next = IDLE;
            an_next    = '1;
            seg_next   = 7'h7F;
            dp_next    = 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with DIGITS = 4. Each slow-clock rise
// is driven by hand and the display is checked for the blanking cycle, the
// newly shown digit and that the digit holds while the slow clock is steady.
// Expected segment patterns are hand-decoded constants.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;

    // Seg value expected on a leading-zero digit: blanked with the feature
    // built in, otherwise a normal "0".
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    logic                clk_in;
    logic                rst_n;
    logic                slow_clk_in;
    logic                enable;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;
    logic [1:0]          digit_idx;

    int checks;
    int failures;

    seg7_scan_driver #(.DIGITS(DIGITS)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .slow_clk_in (slow_clk_in),
        .enable      (enable),
        .value       (value),
        .dp_in       (dp_in),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_idx   (digit_idx)
    );

    // 100 MHz system clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDisplay(input string tag, input logic [3:0] exp_an,
                                input logic [6:0] exp_seg, input logic exp_dp,
                                input logic [1:0] exp_idx);
        checkOutput({tag, "_an"},  32'(an),        32'(exp_an));
        checkOutput({tag, "_seg"}, 32'(seg),       32'(exp_seg));
        checkOutput({tag, "_dp"},  32'(dp),        32'(exp_dp));
        checkOutput({tag, "_idx"}, 32'(digit_idx), 32'(exp_idx));
    endtask

    // One slow-clock period: rise sampled at edge N, blanking visible after
    // edge N+2, new digit after edge N+3, then held for the rest of the period.
    task automatic applyStimulus(input string tag, input logic [3:0] exp_an,
                                 input logic [6:0] exp_seg, input logic exp_dp,
                                 input logic [1:0] exp_idx);
        @(negedge clk_in);
        slow_clk_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput({tag, "_blank_an"}, 32'(an), 32'hF);
        @(negedge clk_in);
        checkDisplay(tag, exp_an, exp_seg, exp_dp, exp_idx);
        repeat (20) @(negedge clk_in);
        checkOutput({tag, "_hold_an"}, 32'(an), 32'(exp_an));
        slow_clk_in = 1'b0;
        repeat (20) @(negedge clk_in);
        checkOutput({tag, "_hold2_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        slow_clk_in = 1'b0;
        enable      = 1'b0;
        value       = '0;
        dp_in       = '0;

        repeat (3) @(negedge clk_in);
        checkDisplay("reset", 4'hF, 7'h7F, 1'b1, 2'd0);
        rst_n = 1'b1;

        // Ticks with enable low must leave the display dark.
        @(negedge clk_in);
        slow_clk_in = 1'b1;
        repeat (6) @(negedge clk_in);
        checkDisplay("idle_dark", 4'hF, 7'h7F, 1'b1, 2'd0);
        slow_clk_in = 1'b0;
        repeat (6) @(negedge clk_in);

        // Scan order on 0x12AF with the decimal point on digit 2.
        enable = 1'b1;
        value  = 16'h12AF;
        dp_in  = 4'b0100;
        applyStimulus("scan_d0", 4'hE, 7'h0E, 1'b1, 2'd0);
        applyStimulus("scan_d1", 4'hD, 7'h08, 1'b1, 2'd1);
        applyStimulus("scan_d2", 4'hB, 7'h24, 1'b0, 2'd2);
        applyStimulus("scan_d3", 4'h7, 7'h79, 1'b1, 2'd3);
        applyStimulus("wrap_d0", 4'hE, 7'h0E, 1'b1, 2'd0);
        applyStimulus("wrap_d1", 4'hD, 7'h08, 1'b1, 2'd1);
        applyStimulus("wrap_d2", 4'hB, 7'h24, 1'b0, 2'd2);

        // Value changes mid-frame: digit 3 still comes from the old snapshot.
        value = 16'h0000;
        applyStimulus("snap_d3", 4'h7, 7'h79, 1'b1, 2'd3);
        applyStimulus("snap_d0", 4'hE, 7'h40, 1'b1, 2'd0);
        applyStimulus("snap_d1", 4'hD, LZ_SEG, 1'b1, 2'd1);

        // Enable drop goes dark on the next edge; restart recaptures.
        @(negedge clk_in);
        enable = 1'b0;
        @(negedge clk_in);
        checkOutput("endrop_an",  32'(an),  32'hF);
        checkOutput("endrop_seg", 32'(seg), 32'h7F);
        checkOutput("endrop_dp",  32'(dp),  32'h1);
        repeat (4) @(negedge clk_in);
        value  = 16'h0050;
        dp_in  = 4'b0001;
        enable = 1'b1;
        applyStimulus("restart_d0", 4'hE, 7'h40, 1'b0, 2'd0);
        applyStimulus("lz_d1", 4'hD, 7'h12, 1'b1, 2'd1);
        applyStimulus("lz_d2", 4'hB, LZ_SEG, 1'b1, 2'd2);
        applyStimulus("lz_d3", 4'h7, LZ_SEG, 1'b1, 2'd3);

        // Asynchronous reset mid-SHOW: dark before the next rising edge.
        applyStimulus("pre_rst_d0", 4'hE, 7'h40, 1'b0, 2'd0);
        applyStimulus("pre_rst_d1", 4'hD, 7'h12, 1'b1, 2'd1);
        @(negedge clk_in);
        #1;
        rst_n = 1'b0;
        #1;
        checkDisplay("async_rst", 4'hF, 7'h7F, 1'b1, 2'd0);
        repeat (2) @(negedge clk_in);
        checkDisplay("rst_hold", 4'hF, 7'h7F, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
